// File: rtl/jtag_config_tap_if.sv
// JTAG pin bundle plus the eFPGA configuration write port of jtag_config_tap.
// JTAG_TAP_TRST_EN adds the optional trst_i line.
interface jtag_config_tap_if;
  logic        tck_i;
  logic        tms_i;
  logic        tdi_i;
  logic        tdo_o;
  logic [31:0] config_data_o;
  logic        config_strobe_o;
  logic        tap_reset_o;
`ifdef JTAG_TAP_TRST_EN
  logic        trst_i;
`endif

  modport master (
    input  tdo_o, config_data_o, config_strobe_o, tap_reset_o,
    output tck_i, tms_i, tdi_i
`ifdef JTAG_TAP_TRST_EN
    , trst_i
`endif
  );

  modport slave (
    input  tck_i, tms_i, tdi_i,
`ifdef JTAG_TAP_TRST_EN
    input  trst_i,
`endif
    output tdo_o, config_data_o, config_strobe_o, tap_reset_o
  );
endinterface

// File: rtl/jtag_config_tap.sv
// Oversampled IEEE 1149.1 TAP with IDCODE, BYPASS and a 32-bit USER register feeding
// the eFPGA config port. Define JTAG_TAP_TRST_EN to add the synchronized trst_i input.
module jtag_config_tap #(
  parameter int                   IR_WIDTH     = 5,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = 5'h01,
  parameter logic [IR_WIDTH-1:0]  USER_INSTR   = 5'h08
) (
  input logic               clk_system_i,
  input logic               reset_i,
  jtag_config_tap_if.slave  jtag
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  tap_state_e          state, state_nxt;
  logic [2:0]          tck_sync;
  logic [1:0]          tms_sync, tdi_sync;
  logic                tck_rise, tck_fall, tms, tdi, trst, step;
  logic [IR_WIDTH-1:0] ir_sr, ir;
  logic [31:0]         dr_sr, cfg_q;
  logic                byp_sr, strobe_q, tdo_q;
  logic                sel_idcode, sel_user, sel_byp;

  always_ff @(posedge clk_system_i or posedge reset_i) begin
    if (reset_i) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
    end else begin
      tck_sync <= {tck_sync[1:0], jtag.tck_i};
      tms_sync <= {tms_sync[0], jtag.tms_i};
      tdi_sync <= {tdi_sync[0], jtag.tdi_i};
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_sync[2];
  assign tck_fall = ~tck_sync[1] & tck_sync[2];
  assign tms      = tms_sync[1];
  assign tdi      = tdi_sync[1];

`ifdef JTAG_TAP_TRST_EN
  logic [1:0] trst_sync;
  always_ff @(posedge clk_system_i or posedge reset_i) begin
    if (reset_i) trst_sync <= '0;
    else         trst_sync <= {trst_sync[0], jtag.trst_i};
  end
  assign trst = trst_sync[1];
`else
  assign trst = 1'b0;
`endif

  // A pending trst swallows the TCK edge so nothing captures or updates on the way to TLR
  assign step = tck_rise & ~trst;

  always_ff @(posedge clk_system_i or posedge reset_i) begin
    if (reset_i) state <= TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (trst) begin
      state_nxt = TLR;
    end else if (tck_rise) begin
      unique case (state)
        TLR:    state_nxt = tms ? TLR    : RTI;
        RTI:    state_nxt = tms ? SEL_DR : RTI;
        SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
        CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
        SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
        EX1_DR: state_nxt = tms ? UPD_DR : PA_DR;
        PA_DR:  state_nxt = tms ? EX2_DR : PA_DR;
        EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
        UPD_DR: state_nxt = tms ? SEL_DR : RTI;
        SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
        CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
        SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
        EX1_IR: state_nxt = tms ? UPD_IR : PA_IR;
        PA_IR:  state_nxt = tms ? EX2_IR : PA_IR;
        EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
        UPD_IR: state_nxt = tms ? SEL_DR : RTI;
        default: state_nxt = TLR;
      endcase
    end
  end

  // Unknown opcodes fall through to BYPASS
  assign sel_idcode = (ir == IDCODE_INSTR);
  assign sel_user   = (ir == USER_INSTR);
  assign sel_byp    = ~sel_idcode & ~sel_user;

  always_ff @(posedge clk_system_i or posedge reset_i) begin
    if (reset_i) begin
      ir_sr    <= '0;
      ir       <= IDCODE_INSTR;
      dr_sr    <= '0;
      byp_sr   <= 1'b0;
      cfg_q    <= '0;
      strobe_q <= 1'b0;
      tdo_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (step) begin
        unique case (state)
          CAP_IR: ir_sr <= IR_CAPTURE;
          SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
          UPD_IR: ir    <= ir_sr;
          CAP_DR: begin
            if (sel_idcode)    dr_sr  <= IDCODE_VALUE;
            else if (sel_user) dr_sr  <= cfg_q;
            else               byp_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_byp) byp_sr <= tdi;
            else         dr_sr  <= {tdi, dr_sr[31:1]};
          end
          UPD_DR: begin
            if (sel_user) begin
              cfg_q    <= dr_sr;
              strobe_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (state == TLR || trst) ir <= IDCODE_INSTR;
      if (tck_fall) begin
        if (state == SH_DR)      tdo_q <= sel_byp ? byp_sr : dr_sr[0];
        else if (state == SH_IR) tdo_q <= ir_sr[0];
        else                     tdo_q <= 1'b0;
      end
    end
  end

  assign jtag.tdo_o           = tdo_q;
  assign jtag.config_data_o   = cfg_q;
  assign jtag.config_strobe_o = strobe_q;
  assign jtag.tap_reset_o     = (state == TLR);

endmodule

// File: tb/tb_jtag_config_tap.sv
// Randomized bench for jtag_config_tap: bit-stream reference model of the TAP registers,
// scenario tasks comparing TDO streams, config word and strobe activity.
module tb_jtag_config_tap;
  localparam logic [31:0] IDCODE = 32'h1000_0001;
  localparam logic [4:0]  IDI    = 5'h01;
  localparam logic [4:0]  USI    = 5'h08;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_config_tap_if jif();
  jtag_config_tap dut (.clk_system_i(clk), .reset_i(rst), .jtag(jif));

  int vec  = 0;
  int miss = 0;

  // strobe monitor
  int          strobe_cnt  = 0;
  int          strobe_wide = 0;
  logic        strobe_prev = 1'b0;
  logic [31:0] strobe_data = '0;
  always @(negedge clk) begin
    if (jif.config_strobe_o === 1'b1) begin
      strobe_cnt++;
      strobe_data = jif.config_data_o;
      if (strobe_prev === 1'b1) strobe_wide++;
    end
    strobe_prev = jif.config_strobe_o;
  end

  // reference model state
  logic [4:0]  m_ir  = IDI;
  logic [31:0] m_cfg = '0;

  // DR as a bit stream: captured bits leave first, then the shifted-in bits follow
  function automatic void model_dr(input int n, input logic [63:0] d,
                                   output logic [63:0] exp_out, output logic [31:0] new_cfg);
    logic [127:0] s;
    logic [63:0]  m;
    if (m_ir == IDI)      s = ({64'b0, d} << 32) | {96'b0, IDCODE};
    else if (m_ir == USI) s = ({64'b0, d} << 32) | {96'b0, m_cfg};
    else                  s = ({64'b0, d} << 1);
    m       = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    exp_out = s[63:0] & m;
    new_cfg = (m_ir == USI) ? s[n +: 32] : m_cfg;
  endfunction

  function automatic void model_ir(input int n, input logic [63:0] d,
                                   output logic [63:0] exp_out, output logic [4:0] new_ir);
    logic [127:0] s;
    logic [63:0]  m;
    s       = ({64'b0, d} << 5) | 128'd1;
    m       = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    exp_out = s[63:0] & m;
    new_ir  = s[n +: 5];
  endfunction

  task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo);
    jif.tms_i = tms;
    jif.tdi_i = tdi;
    repeat (2) @(posedge clk);
    #1 tdo = jif.tdo_o;
    jif.tck_i = 1'b1;
    repeat (6) @(posedge clk);
    #1 jif.tck_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic goto_rti();
    logic b;
    repeat (5) tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    m_ir = IDI;
  endtask

  task automatic ir_scan(input int n, input logic [63:0] d, output logic [63:0] out);
    logic b;
    out = '0;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, d[i], b);
      out[i] = b;
    end
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] d, output logic [63:0] out);
    logic b;
    out = '0;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_pulse(i == n - 1, d[i], b);
      out[i] = b;
    end
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
  endtask

  task automatic test_reset();
    jif.tck_i = 1'b0; jif.tms_i = 1'b0; jif.tdi_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec += 4;
    if (jif.tdo_o !== 1'b0) begin miss++; $display("FAIL reset_tdo got %b want 0", jif.tdo_o); end
    if (jif.config_data_o !== 32'h0) begin miss++; $display("FAIL reset_cfg got %h want 0", jif.config_data_o); end
    if (jif.config_strobe_o !== 1'b0) begin miss++; $display("FAIL reset_strobe got %b want 0", jif.config_strobe_o); end
    if (jif.tap_reset_o !== 1'b1) begin miss++; $display("FAIL reset_tap got %b want 1", jif.tap_reset_o); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_idcode();
    logic [63:0] out, exp;
    logic [31:0] nc;
    goto_rti();
    vec++;
    if (jif.tap_reset_o !== 1'b0) begin miss++; $display("FAIL rti_tap_reset got %b want 0", jif.tap_reset_o); end
    dr_scan(32, 64'h0, out);
    vec++;
    if (out[31:0] !== IDCODE) begin miss++; $display("FAIL idcode_scan got %h want %h", out[31:0], IDCODE); end
    model_dr(32, 64'h0, exp, nc);
    vec++;
    if (out !== exp) begin miss++; $display("FAIL idcode_model got %h want %h", out, exp); end
  endtask

  task automatic test_bypass();
    logic [63:0] out, exp;
    logic [31:0] nc;
    logic [4:0]  ni;
    ir_scan(5, 64'h1F, out);
    model_ir(5, 64'h1F, exp, ni);
    vec++;
    if (out[1:0] !== 2'b01) begin miss++; $display("FAIL ir_capture got %b want 01 (lsb first 1,0)", out[1:0]); end
    vec++;
    if (out !== exp) begin miss++; $display("FAIL ir_capture_full got %h want %h", out, exp); end
    m_ir = ni;
    model_dr(8, 64'hB2, exp, nc);
    dr_scan(8, 64'hB2, out);
    vec++;
    if (out[7:0] !== 8'h64) begin miss++; $display("FAIL bypass_pattern got %h want 64", out[7:0]); end
    vec++;
    if (out !== exp) begin miss++; $display("FAIL bypass_model got %h want %h", out, exp); end
  endtask

  task automatic test_user();
    logic [63:0] out, exp;
    logic [31:0] nc, r;
    logic [4:0]  ni;
    int s0;
    ir_scan(5, {59'b0, USI}, out);
    model_ir(5, {59'b0, USI}, exp, ni);
    m_ir = ni;
    s0 = strobe_cnt;
    dr_scan(32, 64'hDEAD_BEEF, out);
    model_dr(32, 64'hDEAD_BEEF, exp, nc);
    m_cfg = nc;
    vec += 4;
    if (jif.config_data_o !== 32'hDEAD_BEEF) begin miss++; $display("FAIL user_cfg got %h want deadbeef", jif.config_data_o); end
    if (strobe_cnt - s0 !== 1) begin miss++; $display("FAIL user_strobe_count got %0d want 1", strobe_cnt - s0); end
    if (strobe_data !== 32'hDEAD_BEEF) begin miss++; $display("FAIL user_strobe_data got %h want deadbeef", strobe_data); end
    if (strobe_wide !== 0) begin miss++; $display("FAIL user_strobe_width got %0d extended want 0", strobe_wide); end
    r = $urandom;
    model_dr(32, {32'b0, r}, exp, nc);
    dr_scan(32, {32'b0, r}, out);
    m_cfg = nc;
    vec += 2;
    if (out[31:0] !== 32'hDEAD_BEEF) begin miss++; $display("FAIL user_readback got %h want deadbeef", out[31:0]); end
    if (jif.config_data_o !== r) begin miss++; $display("FAIL user_cfg2 got %h want %h", jif.config_data_o, r); end
  endtask

  task automatic test_random();
    logic [63:0] out, exp, d;
    logic [31:0] nc;
    logic [4:0]  ni, op;
    int n, nir, s0;
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0:       op = IDI;
        1:       op = USI;
        default: op = 5'($urandom);
      endcase
      nir = $urandom_range(3, 8);
      d = {$urandom, $urandom};
      d[4:0] = op;
      if (nir > 5) d = d << (nir - 5);
      ir_scan(nir, d, out);
      model_ir(nir, d, exp, ni);
      m_ir = ni;
      vec++;
      if (out !== exp) begin miss++; $display("FAIL rand_ir it%0d got %h want %h", it, out, exp); end
      n = $urandom_range(1, 48);
      d = {$urandom, $urandom};
      s0 = strobe_cnt;
      model_dr(n, d, exp, nc);
      dr_scan(n, d, out);
      vec += 3;
      if ((out & ((n >= 64) ? '1 : ((64'd1 << n) - 64'd1))) !== exp) begin
        miss++; $display("FAIL rand_dr it%0d n=%0d ir=%h got %h want %h", it, n, m_ir, out, exp);
      end
      if (jif.config_data_o !== nc) begin miss++; $display("FAIL rand_cfg it%0d got %h want %h", it, jif.config_data_o, nc); end
      if (strobe_cnt - s0 !== ((m_ir == USI) ? 1 : 0)) begin
        miss++; $display("FAIL rand_strobe it%0d got %0d want %0d", it, strobe_cnt - s0, (m_ir == USI) ? 1 : 0);
      end
      m_cfg = nc;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] out, exp, d1, d2;
    logic [31:0] nc;
    logic [4:0]  ni;
    int s0, w0;
    ir_scan(5, {59'b0, USI}, out);
    model_ir(5, {59'b0, USI}, exp, ni);
    m_ir = ni;
    s0 = strobe_cnt;
    w0 = strobe_wide;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    // short word then over-long word, back to back
    model_dr(8, d1, exp, nc);
    dr_scan(8, d1, out);
    m_cfg = nc;
    vec++;
    if (jif.config_data_o !== nc) begin miss++; $display("FAIL short_shift got %h want %h", jif.config_data_o, nc); end
    model_dr(40, d2, exp, nc);
    dr_scan(40, d2, out);
    m_cfg = nc;
    vec += 4;
    if (jif.config_data_o !== d2[39:8]) begin miss++; $display("FAIL long_shift got %h want %h", jif.config_data_o, d2[39:8]); end
    if (out !== exp) begin miss++; $display("FAIL long_shift_tdo got %h want %h", out, exp); end
    if (strobe_cnt - s0 !== 2) begin miss++; $display("FAIL b2b_strobes got %0d want 2", strobe_cnt - s0); end
    if (strobe_wide !== w0) begin miss++; $display("FAIL b2b_width got %0d extended want 0", strobe_wide - w0); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] out;
    logic b;
    int s0;
    ir_scan(5, {59'b0, USI}, out);
    m_ir = USI;
    s0 = strobe_cnt;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    for (int i = 0; i < 10; i++) tck_pulse(1'b0, 1'($urandom), b);
    jif.tck_i = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vec += 4;
    if (jif.config_data_o !== 32'h0) begin miss++; $display("FAIL midrst_cfg got %h want 0", jif.config_data_o); end
    if (jif.tap_reset_o !== 1'b1) begin miss++; $display("FAIL midrst_tap got %b want 1", jif.tap_reset_o); end
    if (jif.tdo_o !== 1'b0) begin miss++; $display("FAIL midrst_tdo got %b want 0", jif.tdo_o); end
    if (jif.config_strobe_o !== 1'b0) begin miss++; $display("FAIL midrst_strobe got %b want 0", jif.config_strobe_o); end
    jif.tck_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    m_ir = IDI;
    m_cfg = '0;
    vec++;
    if (strobe_cnt !== s0) begin miss++; $display("FAIL midrst_no_strobe got %0d want 0", strobe_cnt - s0); end
    goto_rti();
    dr_scan(32, 64'h0, out);
    vec++;
    if (out[31:0] !== IDCODE) begin miss++; $display("FAIL midrst_ir got %h want %h", out[31:0], IDCODE); end
  endtask

`ifdef JTAG_TAP_TRST_EN
  task automatic test_trst();
    logic [63:0] out, exp;
    logic [31:0] nc, v;
    logic b, seen;
    int s0;
    ir_scan(5, {59'b0, USI}, out);
    m_ir = USI;
    v = $urandom;
    model_dr(32, {32'b0, v}, exp, nc);
    dr_scan(32, {32'b0, v}, out);
    m_cfg = nc;
    s0 = strobe_cnt;
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) tck_pulse(1'b0, 1'($urandom), b);
    tck_pulse(1'b1, 1'b0, b);
    tck_pulse(1'b0, 1'b0, b);
    vec++;
    if (jif.tap_reset_o !== 1'b0) begin miss++; $display("FAIL trst_pre got %b want 0", jif.tap_reset_o); end
    jif.trst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 if (jif.tap_reset_o === 1'b1) seen = 1'b1;
    end
    vec++;
    if (!seen) begin miss++; $display("FAIL trst_tap got %b want 1 within 3 cycles", jif.tap_reset_o); end
    repeat (2) @(posedge clk);
    #1 jif.trst_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    m_ir = IDI;
    vec += 2;
    if (jif.config_data_o !== m_cfg) begin miss++; $display("FAIL trst_cfg got %h want %h", jif.config_data_o, m_cfg); end
    if (strobe_cnt !== s0) begin miss++; $display("FAIL trst_strobe got %0d want 0", strobe_cnt - s0); end
    goto_rti();
    dr_scan(32, 64'h0, out);
    vec++;
    if (out[31:0] !== IDCODE) begin miss++; $display("FAIL trst_ir got %h want %h", out[31:0], IDCODE); end
  endtask
`endif

  initial begin
    jif.tck_i = 1'b0;
    jif.tms_i = 1'b0;
    jif.tdi_i = 1'b0;
`ifdef JTAG_TAP_TRST_EN
    jif.trst_i = 1'b0;
`endif
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef JTAG_TAP_TRST_EN
    test_trst();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
